instr_sequencer: RTL and testbench

Multicycle fetch/decode/execute sequencer for the 16-bit CR16-subset processor. It owns the PC, instruction register and PSR flag register. It fetches from the unified block-RAM memory and drives the register-file read/write ports and the ALU control inputs (`aluop`, `funct`, operand B). It sits directly upstream of the `regfile`/`alucontrol`/ALU datapath, and consumes the ALU result and flags it produces.

---
 rtl/instr_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle FETCH/DECODE/EXEC(/LDWB) control for the 16-bit
// CR16 subset. Owns pc, ir and psr; drives register-file, ALU and memory
// control as pure combinational functions of state, ir and datapath inputs.
//
// Handshake contract (memory and register file, no back-pressure anywhere):
//   - mem_re high with mem_addr in cycle N => mem_rdata holds that word in N+1.
//   - mem_we high with mem_addr/mem_wdata commits at the rising edge ending
//     the cycle; regwrite/wa/wd commit the same way.
//   - rd1/rd2 follow ra1/ra2 combinationally within the cycle.
//
// dbg_state exposes the FSM: 0 = FETCH, 1 = DECODE, 2 = EXEC, 3 = LDWB.
module instr_sequencer #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] rd1,
  input  logic [15:0] rd2,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  output logic [3:0]  wa,
  output logic        regwrite,
  output logic [15:0] wd,
  output logic [1:0]  aluop,
  output logic [5:0]  funct,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic [15:0] pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_LDWB   = 2'd3
  } state_t;

  // ALU function / opcode values shared by register and immediate forms
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;
  localparam logic [3:0] F_ADD    = 4'b0101;
  localparam logic [3:0] F_SUB    = 4'b1001;
  localparam logic [3:0] F_CMP    = 4'b1011;
  localparam logic [3:0] F_MOV    = 4'b1101;
  localparam logic [3:0] X_LOAD   = 4'b0000;
  localparam logic [3:0] X_STOR   = 4'b0100;
  localparam logic [3:0] X_JCOND  = 4'b1100;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;

  // psr / alu_flags bit positions: {C,L,F,Z,N}
  localparam int P_C = 4;
  localparam int P_L = 3;
  localparam int P_F = 2;
  localparam int P_Z = 1;
  localparam int P_N = 0;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  logic [15:0] pc_next;
  logic        psr_load;

  // Instruction fields
  logic [3:0]  opcode;
  logic [3:0]  rdest;
  logic [3:0]  opext;
  logic [3:0]  rsrc;
  logic [7:0]  imm8;

  // Decode results
  logic        is_reg_alu;
  logic        is_imm_alu;
  logic        is_lui;
  logic        is_alu;
  logic [3:0]  alu_code;
  logic        is_arith;
  logic        writes_reg;
  logic        is_load;
  logic        is_stor;
  logic        is_jcond;
  logic        is_bcond;
  logic        cond_true;
  logic [15:0] imm_sext;
  logic [15:0] imm_zext;
  logic [15:0] imm_operand;
  logic [15:0] pc_inc;
  logic [15:0] br_target;

  // True for the seven ALU function codes the datapath implements
  function automatic logic is_alu_code(input logic [3:0] c);
    case (c)
      4'b0001, 4'b0010, 4'b0011,
      4'b0101, 4'b1001, 4'b1011, 4'b1101: is_alu_code = 1'b1;
      default:                            is_alu_code = 1'b0;
    endcase
  endfunction

  assign opcode = ir[15:12];
  assign rdest  = ir[11:8];
  assign opext  = ir[7:4];
  assign rsrc   = ir[3:0];
  assign imm8   = ir[7:0];

  assign imm_sext  = {{8{imm8[7]}}, imm8};
  assign imm_zext  = {8'h00, imm8};
  assign pc_inc    = pc + 16'd1;
  assign br_target = pc + imm_sext;

  // Store data always comes from the Rdest read port
  assign mem_wdata = rd1;
  assign dbg_state = state;

  // Classify the instruction held in ir
  always_comb begin
    is_reg_alu  = (opcode == OP_RTYPE) && is_alu_code(opext);
    // opcode 0000 is never an ALU code, so it cannot alias the R-type group
    is_imm_alu  = is_alu_code(opcode);
    is_lui      = (opcode == OP_LUI);
    is_alu      = is_reg_alu || is_imm_alu || is_lui;
    if (is_reg_alu) begin
      alu_code = opext;
    end else if (is_lui) begin
      alu_code = F_MOV;
    end else begin
      alu_code = opcode;
    end
    // ADD/SUB/CMP (and immediates) are the only flag-producing instructions
    is_arith    = (is_reg_alu || is_imm_alu) &&
                  ((alu_code == F_ADD) || (alu_code == F_SUB) || (alu_code == F_CMP));
    writes_reg  = is_alu && (alu_code != F_CMP);
    // Arithmetic immediates are signed, logical/move immediates are unsigned
    imm_operand = is_arith ? imm_sext : imm_zext;
    is_load     = (opcode == OP_MEM) && (opext == X_LOAD);
    is_stor     = (opcode == OP_MEM) && (opext == X_STOR);
    is_jcond    = (opcode == OP_MEM) && (opext == X_JCOND);
    is_bcond    = (opcode == OP_BCOND);
  end

  // Evaluate the branch/jump condition held in the Rdest/cond field
  always_comb begin
    cond_true = 1'b0;
    case (rdest)
      4'b0000: cond_true =  psr[P_Z];                // EQ
      4'b0001: cond_true = !psr[P_Z];                // NE
      4'b0010: cond_true =  psr[P_C];                // CS
      4'b0011: cond_true = !psr[P_C];                // CC
      4'b0100: cond_true =  psr[P_L];                // HI
      4'b0101: cond_true = !psr[P_L];                // LS
      4'b0110: cond_true =  psr[P_N];                // GT
      4'b0111: cond_true = !psr[P_N];                // LE
      4'b1000: cond_true =  psr[P_F];                // FS
      4'b1001: cond_true = !psr[P_F];                // FC
      4'b1010: cond_true = !psr[P_L] && !psr[P_Z];   // LO
      4'b1011: cond_true =  psr[P_L] ||  psr[P_Z];   // HS
      4'b1100: cond_true = !psr[P_N] && !psr[P_Z];   // LT
      4'b1101: cond_true =  psr[P_N] ||  psr[P_Z];   // GE
      4'b1110: cond_true = 1'b1;                     // UC
      default: cond_true = 1'b0;                     // never
    endcase
  end

  // Next-state and all datapath control outputs
  always_comb begin
    next_state = state;
    pc_next    = pc;
    psr_load   = 1'b0;
    mem_addr   = pc;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ra1        = 4'h0;
    ra2        = 4'h0;
    wa         = 4'h0;
    regwrite   = 1'b0;
    wd         = alu_result;
    aluop      = ALUOP_ADD;
    funct      = 6'b000000;
    alu_b      = 16'h0000;

    unique case (state)
      S_FETCH: begin
        mem_re     = 1'b1;
        next_state = S_DECODE;
      end

      S_DECODE: begin
        next_state = S_EXEC;
      end

      S_EXEC: begin
        ra1        = rdest;
        ra2        = rsrc;
        next_state = S_FETCH;
        pc_next    = pc_inc;
        if (is_alu) begin
          aluop    = ALUOP_FUNCT;
          funct    = {2'b00, alu_code};
          wa       = rdest;
          regwrite = writes_reg;
          wd       = alu_result;
          psr_load = is_arith;
          if (is_reg_alu) begin
            alu_b = rd2;
          end else if (is_lui) begin
            alu_b = {imm8, 8'h00};
          end else begin
            alu_b = imm_operand;
          end
        end else if (is_load) begin
          // Read issued now, data returns during LDWB; pc advances there
          mem_addr   = rd2;
          mem_re     = 1'b1;
          pc_next    = pc;
          next_state = S_LDWB;
        end else if (is_stor) begin
          mem_addr = rd2;
          mem_we   = 1'b1;
        end else if (is_jcond) begin
          pc_next = cond_true ? rd2 : pc_inc;
        end else if (is_bcond) begin
          pc_next = cond_true ? br_target : pc_inc;
        end
        // Any other encoding falls through as a NOP with pc+1
      end

      S_LDWB: begin
        ra1        = rdest;
        ra2        = rsrc;
        wa         = rdest;
        mem_addr   = rd2;
        regwrite   = 1'b1;
        wd         = mem_rdata;
        pc_next    = pc_inc;
        next_state = S_FETCH;
      end

      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // State, pc, ir and psr registers; reset forces FETCH so no write strobe can assert
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= PC_RESET;
      ir    <= 16'h0000;
      psr   <= 5'b00000;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (state == S_DECODE) begin
        ir <= mem_rdata;
      end
      if (psr_load) begin
        psr <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: drives instr_sequencer with a behavioural memory,
// register file and ALU, and checks it against an instruction-level model.
module tb_instr_sequencer;

  localparam logic [15:0] PC_RESET = 16'h0000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  wa;
  logic        regwrite;
  logic [15:0] wd;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic [15:0] pc;
  logic [1:0]  dbg_state;

  instr_sequencer #(.PC_RESET(PC_RESET)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .rd1        (rd1),
    .rd2        (rd2),
    .ra1        (ra1),
    .ra2        (ra2),
    .wa         (wa),
    .regwrite   (regwrite),
    .wd         (wd),
    .aluop      (aluop),
    .funct      (funct),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .psr        (psr),
    .pc         (pc),
    .dbg_state  (dbg_state)
  );

  // ---------------- ALU behaviour (flags {C,L,F,Z,N}) ----------------
  // ADD/SUB report carry/borrow and signed overflow; CMP reports Z, L (unsigned
  // Rdest<Rsrc) and N (signed Rdest<Rsrc); other functions report no flags.
  function automatic logic [20:0] alu_f(input logic [5:0] f, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  fl;
    r  = 16'h0;
    fl = 5'b0;
    s  = 17'h0;
    case (f)
      6'h01: r = a & b;
      6'h02: r = a | b;
      6'h03: r = a ^ b;
      6'h05: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        fl[4] = s[16];
        fl[2] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      6'h09: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0];
        fl[4] = s[16];
        fl[2] = (a[15] != b[15]) && (r[15] != a[15]);
      end
      6'h0B: begin
        r = a - b;
        fl[1] = (a == b);
        fl[3] = (a < b);
        fl[0] = ($signed(a) < $signed(b));
      end
      6'h0D: r = b;
      default: r = 16'h0;
    endcase
    return {fl, r};
  endfunction

  // ---------------- memory, register file, ALU hookup ----------------
  logic [15:0] mem [256];
  logic [15:0] rf  [16];
  logic [20:0] alu_out;

  assign rd1        = rf[ra1];
  assign rd2        = rf[ra2];
  assign alu_out    = alu_f((aluop == 2'b01) ? 6'h05 : funct, rd1, alu_b);
  assign alu_result = alu_out[15:0];
  assign alu_flags  = alu_out[20:16];

  always @(posedge clk) begin
    if (regwrite) rf[wa] <= wd;
    if (mem_we)   mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re)   mem_rdata <= mem[mem_addr[7:0]];
  end

  // ---------------- instruction-level reference model ----------------
  logic [15:0] m_pc;
  logic [4:0]  m_psr;
  logic [15:0] m_rf  [16];
  logic [15:0] m_mem [256];

  int          e_lat;
  int          e_wr_cyc;
  logic [15:0] e_wd;
  logic        e_store;
  logic        e_load;
  logic        e_alu;
  logic [5:0]  e_funct;
  logic [15:0] e_alub;
  logic [15:0] e_maddr;
  logic [15:0] e_wdata;

  function automatic logic alu_ok(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h2) || (c == 4'h3) || (c == 4'h5) ||
           (c == 4'h9) || (c == 4'hB) || (c == 4'hD);
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] p);
    logic cf, lf, ff, zf, nf;
    {cf, lf, ff, zf, nf} = p;
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return lf;
      4'd5:  return !lf;
      4'd6:  return nf;
      4'd7:  return !nf;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !lf && !zf;
      4'd11: return lf || zf;
      4'd12: return !nf && !zf;
      4'd13: return nf || zf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Execute one instruction on the model and record what the DUT should show
  task automatic model_step();
    logic [15:0] ins, a, b;
    logic [3:0]  op, rd, ox, rs, code;
    logic [7:0]  imm;
    logic [20:0] ao;
    logic        is_reg, is_imm;
    ins = m_mem[m_pc[7:0]];
    {op, rd, ox, rs} = ins;
    imm = ins[7:0];
    e_lat = 3; e_wr_cyc = -1; e_wd = 16'h0; e_store = 1'b0; e_load = 1'b0;
    e_alu = 1'b0; e_funct = 6'h0; e_alub = 16'h0; e_maddr = 16'h0; e_wdata = 16'h0;
    is_reg = (op == 4'h0) && alu_ok(ox);
    is_imm = alu_ok(op);
    if (is_reg || is_imm || op == 4'hF) begin
      code = is_reg ? ox : ((op == 4'hF) ? 4'hD : op);
      a = m_rf[rd];
      if (is_reg)                                   b = m_rf[rs];
      else if (op == 4'hF)                          b = {imm, 8'h00};
      else if (code == 4'h5 || code == 4'h9 || code == 4'hB) b = {{8{imm[7]}}, imm};
      else                                          b = {8'h00, imm};
      ao = alu_f({2'b00, code}, a, b);
      e_alu = 1'b1; e_funct = {2'b00, code}; e_alub = b;
      if (code != 4'hB) begin
        e_wr_cyc = 2; e_wd = ao[15:0]; m_rf[rd] = ao[15:0];
      end
      if (code == 4'h5 || code == 4'h9 || code == 4'hB) m_psr = ao[20:16];
      m_pc = m_pc + 16'd1;
    end else if (op == 4'h4 && ox == 4'h0) begin
      e_load = 1'b1; e_lat = 4; e_maddr = m_rf[rs];
      e_wd = m_mem[e_maddr[7:0]]; e_wr_cyc = 3;
      m_rf[rd] = e_wd;
      m_pc = m_pc + 16'd1;
    end else if (op == 4'h4 && ox == 4'h4) begin
      e_store = 1'b1; e_maddr = m_rf[rs]; e_wdata = m_rf[rd];
      m_mem[e_maddr[7:0]] = e_wdata;
      m_pc = m_pc + 16'd1;
    end else if (op == 4'h4 && ox == 4'hC) begin
      m_pc = cond_ok(rd, m_psr) ? m_rf[rs] : m_pc + 16'd1;
    end else if (op == 4'hC) begin
      m_pc = cond_ok(rd, m_psr) ? m_pc + {{8{imm[7]}}, imm} : m_pc + 16'd1;
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int we_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic put_mem(input int a, input logic [15:0] v);
    mem[a] <= v;
    m_mem[a] = v;
  endtask

  task automatic put_rf(input int i, input logic [15:0] v);
    rf[i] <= v;
    m_rf[i] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state",    32'(dbg_state), 32'd0);
    check("rst_pc",       32'(pc),        32'(PC_RESET));
    check("rst_psr",      32'(psr),       32'd0);
    check("rst_mem_addr", 32'(mem_addr),  32'(PC_RESET));
    check("rst_mem_re",   32'(mem_re),    32'd1);
    check("rst_mem_we",   32'(mem_we),    32'd0);
    check("rst_regwrite", 32'(regwrite),  32'd0);
    check("rst_ra",       32'({ra1, ra2, wa}), 32'd0);
    check("rst_aluop",    32'(aluop),     32'd1);
    check("rst_funct",    32'(funct),     32'd0);
    check("rst_alu_b",    32'(alu_b),     32'd0);
    m_pc  = PC_RESET;
    m_psr = 5'b0;
    rst_n = 1'b1;
  endtask

  // Run one instruction, comparing outputs every cycle and state at the end.
  // Entered and left at the falling edge inside a FETCH cycle.
  task automatic run_instr();
    logic [15:0] pc0;
    pc0 = m_pc;
    model_step();
    for (int c = 0; c < e_lat; c++) begin
      check("state",    32'(dbg_state), 32'(c));
      check("pc_hold",  32'(pc),        32'(pc0));
      check("mem_we",   32'(mem_we),    32'((c == 2) && e_store));
      check("regwrite", 32'(regwrite),  32'(c == e_wr_cyc));
      check("aluop",    32'(aluop),     ((c == 2) && e_alu) ? 32'd0 : 32'd1);
      if (c == 0) begin
        check("fetch_re",   32'(mem_re),   32'd1);
        check("fetch_addr", 32'(mem_addr), 32'(pc0));
      end
      if (c == e_wr_cyc) check("wd", 32'(wd), 32'(e_wd));
      if (c == 2 && e_alu) begin
        check("funct", 32'(funct), 32'(e_funct));
        check("alu_b", 32'(alu_b), 32'(e_alub));
      end
      if (c == 2 && (e_load || e_store)) check("ls_addr", 32'(mem_addr), 32'(e_maddr));
      if (c == 2 && e_load)  check("ld_re",  32'(mem_re),    32'd1);
      if (c == 2 && e_store) check("st_data", 32'(mem_wdata), 32'(e_wdata));
      if (mem_we) we_seen++;
      @(negedge clk);
    end
    check("pc_next", 32'(pc),  32'(m_pc));
    check("psr",     32'(psr), 32'(m_psr));
    for (int i = 0; i < 16; i++) begin
      if (rf[i] !== m_rf[i]) check($sformatf("rf%0d", i), 32'(rf[i]), 32'(m_rf[i]));
    end
    if (e_store) check("st_mem", 32'(mem[e_maddr[7:0]]), 32'(m_mem[e_maddr[7:0]]));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] codes [7];
    int k;
    codes = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    k = $urandom_range(0, 99);
    if (k < 30) return {4'h0, 4'($urandom_range(0, 15)), codes[$urandom_range(0, 6)],
                        4'($urandom_range(0, 15))};
    if (k < 55) return {codes[$urandom_range(0, 6)], 4'($urandom_range(0, 15)),
                        8'($urandom_range(0, 255))};
    if (k < 60) return {4'hF, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
    if (k < 68) return {4'h4, 4'($urandom_range(0, 15)), 4'h0, 4'($urandom_range(0, 15))};
    if (k < 76) return {4'h4, 4'($urandom_range(0, 15)), 4'h4, 4'($urandom_range(0, 15))};
    if (k < 84) return {4'h4, 4'($urandom_range(0, 15)), 4'hC, 4'($urandom_range(0, 15))};
    if (k < 94) return {4'hC, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
    return 16'($urandom_range(0, 65535));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) put_mem(i, 16'h0000);
    for (int i = 0; i < 16; i++)  put_rf(i, 16'h0000);
    put_mem(8'h00, 16'h5103);  // ADDI R1,3
    put_mem(8'h01, 16'h0051);  // ADD R0,R1
    put_mem(8'h02, 16'h00B0);  // CMP R0,R0
    put_mem(8'h03, 16'hCE0D);  // BR UC +13 -> 0x10
    put_mem(8'h0E, 16'h5501);  // ADDI R5,1 (clears Z)
    put_mem(8'h0F, 16'h6000);  // NOP encoding
    put_mem(8'h10, 16'hC0FE);  // BEQ -2
    put_mem(8'h11, 16'hD220);  // MOVI R2,0x20
    put_mem(8'h12, 16'h4302);  // LOAD R3,[R2]
    put_mem(8'h13, 16'hF312);  // LUI R3,0x12
    put_mem(8'h14, 16'h2334);  // ORI R3,0x34
    put_mem(8'h15, 16'h4342);  // STOR R3,[R2]
    put_mem(8'h16, 16'h5105);  // ADDI R1,5 (aborted by reset)
    put_mem(8'h20, 16'hBEEF);
    do_reset();

    run_instr();
    check("t1_r1",  32'(rf[1]), 32'h0003);
    check("t1_pc",  32'(pc),    32'h0001);
    check("t1_psr", 32'(psr),   32'h00);

    put_rf(0, 16'hFFFF);
    put_rf(1, 16'hFFFF);
    #1;
    run_instr();
    check("t2_add_r0", 32'(rf[0]),  32'hFFFE);
    check("t2_add_c",  32'(psr[4]), 32'd1);
    run_instr();
    check("t2_cmp_z",  32'(psr[1]), 32'd1);
    check("t2_cmp_r0", 32'(rf[0]),  32'hFFFE);

    run_instr();
    check("t3_br_uc", 32'(pc), 32'h0010);
    run_instr();
    check("t3_beq_taken", 32'(pc), 32'h000E);
    run_instr();
    check("t3_z_clear", 32'(psr[1]), 32'd0);
    run_instr();
    check("t3_nop_pc", 32'(pc), 32'h0010);
    run_instr();
    check("t3_beq_not_taken", 32'(pc), 32'h0011);

    run_instr();
    check("t4_movi_r2", 32'(rf[2]), 32'h0020);
    run_instr();
    check("t4_load_r3", 32'(rf[3]), 32'hBEEF);
    run_instr();
    run_instr();
    check("t5_r3", 32'(rf[3]), 32'h1234);
    we_seen = 0;
    run_instr();
    check("t5_we_pulses", 32'(we_seen), 32'd1);
    check("t5_mem20",     32'(mem[8'h20]), 32'h1234);

    // Reset asserted during EXEC of ADDI R1,5
    check("t6_fetch_pc", 32'(pc), 32'h0016);
    @(negedge clk);
    @(negedge clk);
    check("t6_exec_rw", 32'(regwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_state",    32'(dbg_state), 32'd0);
    check("t6_pc",       32'(pc),        32'(PC_RESET));
    check("t6_regwrite", 32'(regwrite),  32'd0);
    check("t6_mem_re",   32'(mem_re),    32'd1);
    @(posedge clk);
    #1;
    check("t6_r1_kept", 32'(rf[1]), 32'hFFFF);
    @(negedge clk);

    // Randomized programs against the model
    for (int i = 0; i < 256; i++) put_mem(i, rand_instr());
    for (int i = 0; i < 16; i++)  put_rf(i, 16'($urandom_range(0, 65535)));
    do_reset();
    repeat (400) run_instr();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the sequence above is bounded, this only guards against a stuck sim
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
